// File: rtl/sm_boot_ctrl.sv
// Serial boot loader: receives an 0xA5-framed word stream, writes it into instruction memory
// and holds the CPU in reset while loading. Optional checksum stage enabled by SM_BOOT_CSUM_EN.
module sm_boot_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [31:0]       imem_wd,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef SM_BOOT_CSUM_EN
    typedef enum logic [2:0] {RUN, LEN, DATA, CSUM, ERR} state_t;
`else
    typedef enum logic [2:0] {RUN, LEN, DATA, ERR} state_t;
`endif

    localparam logic [16:0] IDLE_LAST = 17'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        loading;
    logic        next_loading;
    logic        timeout_hit;
    logic        last_byte;
    logic        word_done;
    logic        enter_run;
    logic [16:0] idle_cnt;
    logic [7:0]  words_left;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
`ifdef SM_BOOT_CSUM_EN
    logic [7:0]  csum;
`endif

    assign accept = rx_valid && rx_ready;
`ifdef SM_BOOT_CSUM_EN
    assign loading      = (state == LEN) || (state == DATA) || (state == CSUM);
    assign next_loading = (next_state == LEN) || (next_state == DATA) || (next_state == CSUM);
`else
    assign loading      = (state == LEN) || (state == DATA);
    assign next_loading = (next_state == LEN) || (next_state == DATA);
`endif
    // The timeout fires on the last idle cycle so the error state is entered exactly TIMEOUT idle cycles after the last byte
    assign timeout_hit = loading && !accept && (idle_cnt == IDLE_LAST);
    assign last_byte   = (byte_idx == 2'd3) && (words_left == 8'd1);
    assign word_done   = accept && (state == DATA) && (byte_idx == 2'd3);

    always_comb begin
        next_state = state;
        enter_run  = 1'b0;
        case (state)
            RUN: begin
                if (accept && rx_data == 8'hA5) next_state = LEN;
            end
            LEN: begin
                if (timeout_hit)  next_state = ERR;
                else if (accept)  next_state = (rx_data == 8'd0) ? ERR : DATA;
            end
            DATA: begin
                if (timeout_hit) begin
                    next_state = ERR;
                end else if (accept && last_byte) begin
`ifdef SM_BOOT_CSUM_EN
                    next_state = CSUM;
`else
                    next_state = RUN;
                    enter_run  = 1'b1;
`endif
                end
            end
`ifdef SM_BOOT_CSUM_EN
            CSUM: begin
                if (timeout_hit) begin
                    next_state = ERR;
                end else if (accept) begin
                    if (rx_data == csum) begin
                        next_state = RUN;
                        enter_run  = 1'b1;
                    end else begin
                        next_state = ERR;
                    end
                end
            end
`endif
            ERR: begin
                if (accept && rx_data == 8'hA5) next_state = LEN;
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            rx_ready  <= 1'b0;
            cpu_rst_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= next_state;
            rx_ready  <= 1'b1;
            cpu_rst_n <= (next_state == RUN);
            busy      <= next_loading;
            done      <= enter_run;
            err       <= (next_state == ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_wa    <= '0;
            imem_wd    <= '0;
            idle_cnt   <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
`ifdef SM_BOOT_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= word_done;
            if (word_done) imem_wd <= {rx_data, word_buf};
            if (imem_we)   imem_wa <= imem_wa + 1'b1;

            if (accept || !loading) idle_cnt <= '0;
            else                    idle_cnt <= idle_cnt + 17'd1;

            if (state == LEN && accept) begin
                words_left <= rx_data;
                byte_idx   <= '0;
                imem_wa    <= '0;
`ifdef SM_BOOT_CSUM_EN
                csum       <= '0;
`endif
            end

            if (state == DATA && accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    word_buf[7:0]   <= rx_data;
                    2'd1:    word_buf[15:8]  <= rx_data;
                    2'd2:    word_buf[23:16] <= rx_data;
                    default: words_left      <= words_left - 8'd1;
                endcase
`ifdef SM_BOOT_CSUM_EN
                csum <= csum ^ rx_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sm_boot_ctrl.sv
// Scoreboard bench for sm_boot_ctrl: a byte-queue reference model predicts memory writes,
// done pulses and error entries; a negedge monitor pops and compares them as they appear.
module tb_sm_boot_ctrl;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 16;

    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    localparam int P_RUN  = 0;
    localparam int P_LEN  = 1;
    localparam int P_DATA = 2;
    localparam int P_CSUM = 3;
    localparam int P_ERR  = 4;

    logic              clk;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_wa;
    logic [31:0]       imem_wd;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    sm_boot_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] wa;
        logic [31:0]       wd;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic       err_d  = 1'b0;

    int         phase = P_RUN;
    int         n_words = 0;
    int         words_out = 0;
    logic [7:0] data_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushEv(input int kind, input logic [ADDR_W-1:0] wa, input logic [31:0] wd);
        ev_t e;
        e.kind = kind;
        e.wa   = wa;
        e.wd   = wd;
        exp_q.push_back(e);
    endtask

    // Reference model: load progress is the list of data bytes received so far
    task automatic modelGap(input int gap);
        if ((phase == P_LEN || phase == P_DATA || phase == P_CSUM) && gap >= TIMEOUT) begin
            pushEv(EV_ERR, '0, '0);
            phase = P_ERR;
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        int         s;
        logic [7:0] x;
        case (phase)
            P_RUN, P_ERR: begin
                if (b == 8'hA5) phase = P_LEN;
            end
            P_LEN: begin
                if (b == 8'h00) begin
                    pushEv(EV_ERR, '0, '0);
                    phase = P_ERR;
                end else begin
                    n_words   = int'(b);
                    words_out = 0;
                    data_q.delete();
                    phase = P_DATA;
                end
            end
            P_DATA: begin
                data_q.push_back(b);
                s = data_q.size();
                if (s % 4 == 0) begin
                    pushEv(EV_WR, ADDR_W'(words_out % (1 << ADDR_W)),
                           {data_q[s-1], data_q[s-2], data_q[s-3], data_q[s-4]});
                    words_out++;
                end
                if (s == 4 * n_words) begin
`ifdef SM_BOOT_CSUM_EN
                    phase = P_CSUM;
`else
                    pushEv(EV_DONE, '0, '0);
                    phase = P_RUN;
`endif
                end
            end
            default: begin
                x = 8'h00;
                foreach (data_q[i]) x = x ^ data_q[i];
                if (b == x) begin
                    pushEv(EV_DONE, '0, '0);
                    phase = P_RUN;
                end else begin
                    pushEv(EV_ERR, '0, '0);
                    phase = P_ERR;
                end
            end
        endcase
    endtask

    // Holds rx_valid low for gap cycles, then offers one byte for a single cycle
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        modelGap(gap);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        modelByte(b);
        #1;
        rx_valid = 1'b0;
        checkOutput("rx_ready", rx_ready, 1'b1);
        checkOutput("busy", busy, (phase == P_LEN || phase == P_DATA || phase == P_CSUM));
        checkOutput("err", err, (phase == P_ERR));
        checkOutput("cpu_rst_n", cpu_rst_n, (phase == P_RUN));
    endtask

    task automatic idleCycles(input int n);
        modelGap(n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        phase = P_RUN;
        data_q.delete();
        checkOutput("rst_rx_ready", rx_ready, 1'b0);
        checkOutput("rst_cpu_rst_n", cpu_rst_n, 1'b1);
        checkOutput("rst_imem_we", imem_we, 1'b0);
        checkOutput("rst_imem_wa", imem_wa, '0);
        checkOutput("rst_imem_wd", imem_wd, 32'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rx_ready_after_rst", rx_ready, 1'b1);
    endtask

    task automatic expectEvent(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d, expected none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            if (kind == EV_WR && e.kind == EV_WR) begin
                checkOutput("imem_wa", imem_wa, e.wa);
                checkOutput("imem_wd", imem_wd, e.wd);
            end
        end
    endtask

    // Monitor: every visible write, done pulse or entry into the error state consumes one expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we) expectEvent(EV_WR);
            if (done) expectEvent(EV_DONE);
            if (err && !err_d) expectEvent(EV_ERR);
            err_d = err;
        end
    end

    function automatic int pickGap();
        int r;
        r = $urandom_range(0, 19);
        if (r < 17) return $urandom_range(0, 2);
        if (r == 17) return TIMEOUT - 1;
        return $urandom_range(TIMEOUT, TIMEOUT + 2);
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] x;
        logic [7:0] b;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        err_d  = err;
        mon_en = 1'b1;
        doReset();

        // Single word load with checksum
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h78, 0);
        applyStimulus(8'h56, 1);
        applyStimulus(8'h34, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h08, 0);
        idleCycles(3);

        // Zero length errors out, then a clean load recovers
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h33, 2);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h78, 0);
        applyStimulus(8'h56, 0);
        applyStimulus(8'h34, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h08, 0);
        idleCycles(3);

        // Five words into a four-word address space wrap back to address 0
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h05, 0);
        for (int w = 1; w <= 5; w++) begin
            applyStimulus(8'(w), 0);
            applyStimulus(8'h00, 0);
            applyStimulus(8'h00, 0);
            applyStimulus(8'h00, 0);
        end
        applyStimulus(8'h01, 0);
        idleCycles(3);

        // Wrong checksum, with 0xA5 inside the payload treated as data
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h78, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h34, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h09, 0);
        idleCycles(3);

        // One idle cycle short of the timeout is tolerated; a full stall is not
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, TIMEOUT - 1);
        applyStimulus(8'h78, 0);
        applyStimulus(8'h56, 0);
        applyStimulus(8'h34, TIMEOUT);
        applyStimulus(8'h12, 0);
        idleCycles(3);

        // Reset in the middle of a data word
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        idleCycles(2);
        doReset();
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h78, 0);
        applyStimulus(8'h56, 0);
        applyStimulus(8'h34, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h08, 0);
        idleCycles(3);

        // Randomised loads with occasional junk, timeouts and bad checksums
        for (int l = 0; l < 25; l++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                applyStimulus(b, $urandom_range(0, 3));
            end
            applyStimulus(8'hA5, $urandom_range(0, 2));
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            applyStimulus(8'(n), pickGap());
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom_range(0, 255));
                x = x ^ b;
                applyStimulus(b, pickGap());
            end
`ifdef SM_BOOT_CSUM_EN
            applyStimulus(($urandom_range(0, 4) == 0) ? (x ^ 8'h01) : x, pickGap());
`endif
            idleCycles($urandom_range(1, 3));
        end

        idleCycles(TIMEOUT + 4);
        checkOutput("pending_events", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_boot_ctrl.md
SM_BOOT_CTRL -- requirements
Module: sm_boot_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the instruction-memory word-address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 100000, giving the maximum idle clock cycles between accepted bytes while loading.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports rx_valid (input, 1), rx_data (input, 8) and rx_ready (output, 1) forming the loader byte stream.
REQ-006 The block SHALL have ports imem_we (output, 1), imem_wa (output, ADDR_W) and imem_wd (output, 32) forming the instruction-memory write port.
REQ-007 The block SHALL have port cpu_rst_n, output, 1 bit: CPU reset, low while the CPU is held.
REQ-008 The block SHALL have ports busy, done and err, outputs, 1 bit each, carrying loader status.

Function
REQ-009 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-010 rx_ready SHALL be a register that is 1 in every cycle except the cycle after reset.
REQ-011 The state machine SHALL have states RUN, LEN, DATA, CSUM and ERR.
REQ-012 RUN: cpu_rst_n=1; accepting 0xA5 SHALL go to LEN; all other bytes SHALL be ignored.
REQ-013 LEN: the accepted byte SHALL be taken as word count N; N=0 SHALL go to ERR; otherwise the block SHALL go to DATA and clear the word address, byte index and checksum.
REQ-014 DATA: bytes SHALL assemble little-endian, with the first byte going to bits 7:0.
REQ-015 In DATA, the cycle after the 4th byte of a word is accepted, imem_we SHALL be 1 for exactly one cycle with imem_wa and imem_wd valid.
REQ-016 In DATA, imem_wa SHALL then increment modulo 2^ADDR_W, so N greater than 2^ADDR_W wraps and overwrites.
REQ-017 After the 4*N-th data byte the block SHALL go to CSUM (see REQ-026).
REQ-018 CSUM: if the accepted byte equals the XOR of all 4*N data bytes, the block SHALL go to RUN and pulse done for one cycle; otherwise it SHALL go to ERR.
REQ-019 cpu_rst_n SHALL be 0 in LEN, DATA, CSUM and ERR, and SHALL return to 1 the cycle after the transition to RUN.
REQ-020 busy SHALL be 1 in LEN, DATA and CSUM.
REQ-021 err SHALL be 1 while in ERR.
REQ-022 In LEN, DATA and CSUM, a 17-bit idle counter SHALL reset on every accepted byte; reaching TIMEOUT SHALL go to ERR, and any partial word SHALL NOT be written.
REQ-023 ERR SHALL ignore all bytes except 0xA5, which SHALL go to LEN (restarting the load with the CPU still held).
REQ-024 0xA5 received in LEN, DATA or CSUM SHALL be treated as data, not as a restart.

Reset
REQ-025 While rst=1, at the next edge: state=RUN, cpu_rst_n=1, rx_ready=0, imem_we=0, imem_wa=0, imem_wd=0, busy=0, done=0, err=0, counters=0; asserting rst mid-load SHALL abort with no further imem_we.

Configuration
REQ-026 Macro SM_BOOT_CSUM_EN: when defined, the CSUM state and checksum compare SHALL exist per REQ-018.
REQ-027 When SM_BOOT_CSUM_EN is undefined, CSUM and the checksum register SHALL be omitted, and the 4*N-th data byte SHALL go directly to RUN with a done pulse.

Verification
REQ-028 Reset, then 0xA5, 0x01, bytes 78 56 34 12, csum 0x08 -> one imem_we with wa=0, wd=0x12345678; done pulse; cpu_rst_n low from the cycle after 0xA5 until the cycle after the csum byte.
REQ-029 0xA5, 0x00 -> err=1, cpu_rst_n=0, no imem_we; then 0xA5, 0x01, four bytes and a correct csum -> RUN, err=0.
REQ-030 ADDR_W=2, N=5 words 1..5 -> writes at wa 0,1,2,3,0 in order, with the last write wd=5.
REQ-031 A load with a wrong csum (expected 0x08, sent 0x09) -> ERR, err=1, no done pulse; the earlier word write has already occurred.
REQ-032 TIMEOUT=16, stall 16 cycles after 2 data bytes -> ERR, and no imem_we for the partial word.
REQ-033 rst asserted for one cycle mid-DATA -> RUN, cpu_rst_n=1, imem_wa=0; with SM_BOOT_CSUM_EN undefined, the REQ-028 stream without csum -> done after the 4th data byte.
